// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: arbitration mode selector and
// a small index helper used by the round-robin pointer logic.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// One-hot picker: grants the first requester at or after base, wrapping
// N-1 -> 0. With base tied to zero it degenerates to fixed priority.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0] base,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt
);

  logic [IW-1:0] idx;
  logic          found;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx = IW'((int'(base) + j) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter for the single shared memory port: fixed or round-robin
// grant, locked bursts with idle timeout, and read-data routing by tag pipe.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int        N_CH         = 2,
  parameter int        ADDR_W       = 20,
  parameter int        DATA_W       = 32,
  parameter int        READ_LATENCY = 1,
  parameter arb_mode_e ARB_MODE     = ARB_FIXED,
  parameter int        LOCK_MAX     = 15
) (
  input  logic                     clk,
  input  logic                     rst_async,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH-1:0]          req_lock,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_write_enable,
  output logic [DATA_W-1:0]        mem_write_value,
  input  logic [DATA_W-1:0]        mem_read_value
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [IW-1:0]   rr_ptr;
  logic            lock_held;
  logic [N_CH-1:0] lock_owner;
  logic [CW-1:0]   idle_cnt;
  logic [N_CH-1:0] tag_pipe [READ_LATENCY];

  logic [IW-1:0]   pick_base;
  logic [N_CH-1:0] pick_gnt;
  logic [N_CH-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;
  logic            owner_valid;

  assign pick_base   = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
  assign owner_valid = |(lock_owner & req_valid);

  rr_picker #(.N(N_CH), .IW(IW)) u_picker (
    .base (pick_base),
    .req  (req_valid),
    .gnt  (pick_gnt)
  );

  // While locked only the owner can be served, whatever the picker says.
  always_comb begin
    gnt = '0;
    if (!rst_async) gnt = lock_held ? (lock_owner & req_valid) : pick_gnt;
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (gnt[i]) gnt_idx = IW'(i);
  end

  assign xfer             = |gnt;
  assign req_ready        = gnt;
  assign mem_address      = xfer ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
  assign mem_write_value  = xfer ? req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
  assign mem_write_enable = xfer & req_write[gnt_idx];
  assign rsp_valid        = rst_async ? '0 : tag_pipe[READ_LATENCY-1];
  assign rsp_rdata        = mem_read_value;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the tag pipe is explicitly cleared because a stale tag would raise
  // rsp_valid for a read that was discarded by reset.
  always_ff @(posedge clk) begin
    if (rst_async) begin
      rr_ptr     <= '0;
      lock_held  <= 1'b0;
      lock_owner <= '0;
      idle_cnt   <= '0;
      tag_pipe   <= '{default: '0};
    end else begin
      if (xfer && !lock_held) rr_ptr <= IW'(ring_next(int'(gnt_idx), N_CH));

      if (lock_held) begin
        if (owner_valid) begin
          idle_cnt <= '0;
          if (!req_lock[gnt_idx]) lock_held <= 1'b0;
        end else if (idle_cnt == CW'(LOCK_MAX - 1)) begin
          lock_held <= 1'b0;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else if (xfer && req_lock[gnt_idx]) begin
        lock_held  <= 1'b1;
        lock_owner <= gnt;
        idle_cnt   <= '0;
      end

      tag_pipe[0] <= (xfer && !req_write[gnt_idx]) ? gnt : '0;
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: a fixed-priority and a round-robin arbiter share one stimulus stream
// and are compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int LMAX = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_write, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  logic [1:0][N-1:0]  rdy, rspv;
  logic [1:0][DW-1:0] rdata, wval, mrval;
  logic [1:0][AW-1:0] maddr;
  logic [1:0]         mwe;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT0),
    .ARB_MODE(ARB_FIXED), .LOCK_MAX(LMAX)
  ) u_fix (
    .clk(clk), .rst_async(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .mem_address(maddr[0]), .mem_write_enable(mwe[0]),
    .mem_write_value(wval[0]), .mem_read_value(mrval[0])
  );

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT1),
    .ARB_MODE(ARB_RR), .LOCK_MAX(LMAX)
  ) u_rr (
    .clk(clk), .rst_async(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .mem_address(maddr[1]), .mem_write_enable(mwe[1]),
    .mem_write_value(wval[1]), .mem_read_value(mrval[1])
  );

  function automatic logic [DW-1:0] seed(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hA5A5_0000 ^ DW'(a * 32'h0101_0101));
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Memory behind each DUT: 32 words aliased on the low address bits.
  bit [DW-1:0] dut_mem [2][32];
  bit          dut_wr  [2][32];
  logic [DW-1:0] rd_pipe [2][4];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) rd_pipe[k][s] <= rd_pipe[k][s-1];
      rd_pipe[k][0] <= dut_wr[k][maddr[k][4:0]] ? dut_mem[k][maddr[k][4:0]]
                                                : seed(int'(maddr[k][4:0]));
      if (mwe[k]) begin
        dut_mem[k][maddr[k][4:0]] <= wval[k];
        dut_wr[k][maddr[k][4:0]]  <= 1'b1;
      end
    end
  end

  assign mrval[0] = rd_pipe[0][LAT0-1];
  assign mrval[1] = rd_pipe[1][LAT1-1];

  // Reference model state.
  typedef struct {
    int            k;
    int            due;
    int            ch;
    logic [DW-1:0] data;
  } pend_t;

  pend_t       pend [$];
  bit [DW-1:0] ref_mem [2][32];
  bit          ref_wr  [2][32];
  int m_lock [2], m_owner [2], m_idle [2], m_ptr [2];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input int k);
    int base;
    if (m_lock[k] != 0) return req_valid[m_owner[k]] ? m_owner[k] : -1;
    base = (k == 1) ? m_ptr[k] : 0;
    for (int j = 0; j < N; j++)
      if (req_valid[(base + j) % N]) return (base + j) % N;
    return -1;
  endfunction

  task automatic eval_inst(input int k);
    int            g;
    int            a;
    logic [N-1:0]  eg, ersp;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] erd;
    bit            have;
    string         sfx;

    sfx = (k == 0) ? "fix" : "rr";
    g   = rst ? -1 : pick(k);
    eg  = '0;
    if (g >= 0) eg[g] = 1'b1;
    ea  = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    ewe = (g >= 0) && req_write[g];

    check({"ready_", sfx}, 64'(rdy[k]), 64'(eg));
    check({"addr_", sfx}, 64'(maddr[k]), 64'(ea));
    check({"we_", sfx}, 64'(mwe[k]), 64'(ewe));
    if (ewe) check({"wdata_", sfx}, 64'(wval[k]), 64'(req_wdata[g*DW +: DW]));

    ersp = '0;
    erd  = '0;
    have = 1'b0;
    if (!rst)
      foreach (pend[i])
        if (pend[i].k == k && pend[i].due == cyc) begin
          ersp[pend[i].ch] = 1'b1;
          erd  = pend[i].data;
          have = 1'b1;
        end
    check({"rsp_valid_", sfx}, 64'(rspv[k]), 64'(ersp));
    if (have) check({"rsp_rdata_", sfx}, 64'(rdata[k]), 64'(erd));

    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].k == k && (rst || pend[i].due <= cyc)) pend.delete(i);

    if (rst) begin
      m_lock[k] = 0;
      m_idle[k] = 0;
      m_ptr[k]  = 0;
    end else begin
      if (g >= 0) begin
        a = int'(req_addr[g*AW +: 5]);
        if (req_write[g]) begin
          ref_mem[k][a] = req_wdata[g*DW +: DW];
          ref_wr[k][a]  = 1'b1;
        end else begin
          pend.push_back('{k: k, due: cyc + lat(k), ch: g,
                           data: ref_wr[k][a] ? ref_mem[k][a] : seed(a)});
        end
        if (m_lock[k] == 0) m_ptr[k] = (g + 1) % N;
      end
      if (m_lock[k] != 0) begin
        if (req_valid[m_owner[k]]) begin
          m_idle[k] = 0;
          if (!req_lock[m_owner[k]]) m_lock[k] = 0;
        end else begin
          m_idle[k]++;
          if (m_idle[k] == LMAX) begin
            m_lock[k] = 0;
            m_idle[k] = 0;
          end
        end
      end else if (g >= 0 && req_lock[g]) begin
        m_lock[k]  = 1;
        m_owner[k] = g;
        m_idle[k]  = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N-1:0] l);
    rst       = r;
    req_valid = v;
    req_write = w;
    req_lock  = l;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic tick();
    #1;
    eval_inst(0);
    eval_inst(1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input logic r, input logic [N-1:0] v, input logic [N-1:0] w,
                     input logic [N-1:0] l);
    drive(r, v, w, l);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_owner[k] = 0; m_idle[k] = 0; m_ptr[k] = 0;
    end
    drive(1'b1, '1, '0, '0);
    @(negedge clk);

    // Reset held with every channel requesting.
    repeat (3) run(1'b1, '1, '0, '0);

    // ch1 wins over ch2 and reads address 0x10.
    drive(1'b0, 3'b110, 3'b000, 3'b000);
    req_addr[1*AW +: AW] = 20'h00010;
    tick();
    repeat (4) run(1'b0, 3'b000, 3'b000, 3'b000);

    // Rotation from a fresh pointer, then wrap with a partial request set.
    run(1'b1, 3'b000, 3'b000, 3'b000);
    repeat (6) run(1'b0, 3'b111, 3'b000, 3'b000);
    run(1'b0, 3'b001, 3'b000, 3'b000);
    repeat (2) run(1'b0, 3'b101, 3'b000, 3'b000);

    // Locked write burst blocks ch0 until released.
    run(1'b1, 3'b000, 3'b000, 3'b000);
    run(1'b0, 3'b010, 3'b010, 3'b010);
    run(1'b0, 3'b011, 3'b010, 3'b010);
    run(1'b0, 3'b001, 3'b000, 3'b000);
    run(1'b0, 3'b011, 3'b010, 3'b000);
    run(1'b0, 3'b001, 3'b000, 3'b000);

    // Idle owner loses the lock after LMAX cycles.
    run(1'b1, 3'b000, 3'b000, 3'b000);
    run(1'b0, 3'b010, 3'b010, 3'b010);
    repeat (6) run(1'b0, 3'b001, 3'b000, 3'b000);

    // Back-to-back reads interrupted by reset.
    run(1'b1, 3'b000, 3'b000, 3'b000);
    run(1'b0, 3'b001, 3'b000, 3'b000);
    run(1'b0, 3'b010, 3'b000, 3'b000);
    run(1'b0, 3'b001, 3'b000, 3'b000);
    run(1'b0, 3'b000, 3'b000, 3'b000);
    run(1'b1, 3'b000, 3'b000, 3'b000);
    repeat (4) run(1'b0, 3'b000, 3'b000, 3'b000);

    // Random traffic with sparse valids, occasional locks and resets.
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] v, l;
      v = N'($urandom);
      if ($urandom_range(0, 1) == 0) v = v & N'($urandom);
      l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      run($urandom_range(0, 63) == 0, v, N'($urandom), l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
